// File: rtl/id_ex_stage_pkg.sv
// Core-wide widths and control-word layout shared by the decode/execute slice.
package id_ex_stage_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_IDX_W   = 5;
    localparam int CTRL_W      = 16;
    localparam int MEMREAD_BIT = 0;

    // Control-word bit positions produced by the decoder.
    localparam int CTRL_MEMREAD  = MEMREAD_BIT;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_JUMP     = 6;

    // Write-back bypass: x0 is hard-wired to zero and is never forwarded.
    function automatic logic wb_hits(input logic                 regwrite,
                                     input logic [REG_IDX_W-1:0] wb_rd,
                                     input logic [REG_IDX_W-1:0] rs);
        return regwrite && (wb_rd != '0) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module id_ex_stage_hazard_unit
    import id_ex_stage_pkg::*;
(
    input  logic                 i_id_valid,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_ex_valid,
    input  logic                 i_ex_memread,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_flush,
    output logic                 o_stall
);

    logic w_hazard;

    // A load in EX whose result a valid ID instruction needs forces a bubble,
    // unless the ID instruction is being killed by a flush anyway.
    always_comb begin
        w_hazard = i_id_valid && i_ex_valid && i_ex_memread && (i_ex_rd != '0) &&
                   ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
        o_stall  = w_hazard && !i_flush;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble and flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int n           = DATA_W,
    parameter int CTRL_W      = id_ex_stage_pkg::CTRL_W,
    parameter int MEMREAD_BIT = id_ex_stage_pkg::MEMREAD_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_id_valid,
    input  logic [n-1:0]         i_id_pc,
    input  logic [4:0]           i_id_rs1,
    input  logic [4:0]           i_id_rs2,
    input  logic [4:0]           i_id_rd,
    input  logic [n-1:0]         i_id_imm,
    input  logic [CTRL_W-1:0]    i_id_ctrl,
    input  logic [n-1:0]         i_rf_rdata1,
    input  logic [n-1:0]         i_rf_rdata2,
    input  logic                 i_wb_regwrite,
    input  logic [4:0]           i_wb_rd,
    input  logic [n-1:0]         i_wb_data,
    input  logic                 i_flush,
    output logic                 o_stall,
    output logic                 o_ex_valid,
    output logic [n-1:0]         o_ex_pc,
    output logic [4:0]           o_ex_rs1,
    output logic [4:0]           o_ex_rs2,
    output logic [4:0]           o_ex_rd,
    output logic [n-1:0]         o_ex_imm,
    output logic [CTRL_W-1:0]    o_ex_ctrl,
    output logic [n-1:0]         o_ex_op1,
    output logic [n-1:0]         o_ex_op2,
    output logic [31:0]          o_stall_cnt
);

    logic              r_ex_valid;
    logic [n-1:0]      r_ex_pc;
    logic [4:0]        r_ex_rs1;
    logic [4:0]        r_ex_rs2;
    logic [4:0]        r_ex_rd;
    logic [n-1:0]      r_ex_imm;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [n-1:0]      r_ex_op1;
    logic [n-1:0]      r_ex_op2;
    logic [31:0]       r_stall_cnt;

    logic              w_stall;
    logic [4:0]        w_rs      [2];
    logic [n-1:0]      w_rdata   [2];
    logic [n-1:0]      w_op_next [2];

    assign w_rs[0]    = i_id_rs1;
    assign w_rs[1]    = i_id_rs2;
    assign w_rdata[0] = i_rf_rdata1;
    assign w_rdata[1] = i_rf_rdata2;

    // The register file writes on the edge but reads combinationally, so a
    // same-cycle write-back must be forwarded into each captured operand.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            assign w_op_next[gi] = wb_hits(i_wb_regwrite, i_wb_rd, w_rs[gi]) ?
                                   i_wb_data : w_rdata[gi];
        end
    endgenerate

    id_ex_stage_hazard_unit u_hazard (
        .i_id_valid   (i_id_valid),
        .i_id_rs1     (i_id_rs1),
        .i_id_rs2     (i_id_rs2),
        .i_ex_valid   (r_ex_valid),
        .i_ex_memread (r_ex_ctrl[MEMREAD_BIT]),
        .i_ex_rd      (r_ex_rd),
        .i_flush      (i_flush),
        .o_stall      (w_stall)
    );

    // Pipeline update: flush kills, stall bubbles and counts, else capture ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_pc     <= '0;
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_rd     <= '0;
            r_ex_imm    <= '0;
            r_ex_ctrl   <= '0;
            r_ex_op1    <= '0;
            r_ex_op2    <= '0;
            r_stall_cnt <= '0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else if (w_stall) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
            if (r_stall_cnt != 32'hFFFF_FFFF) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end else begin
            r_ex_valid <= i_id_valid;
            r_ex_pc    <= i_id_pc;
            r_ex_rs1   <= i_id_rs1;
            r_ex_rs2   <= i_id_rs2;
            r_ex_rd    <= i_id_rd;
            r_ex_imm   <= i_id_imm;
            r_ex_ctrl  <= i_id_valid ? i_id_ctrl : '0;
            r_ex_op1   <= w_op_next[0];
            r_ex_op2   <= w_op_next[1];
        end
    end

    assign o_stall     = w_stall;
    assign o_ex_valid  = r_ex_valid;
    assign o_ex_pc     = r_ex_pc;
    assign o_ex_rs1    = r_ex_rs1;
    assign o_ex_rs2    = r_ex_rs2;
    assign o_ex_rd     = r_ex_rd;
    assign o_ex_imm    = r_ex_imm;
    assign o_ex_ctrl   = r_ex_ctrl;
    assign o_ex_op1    = r_ex_op1;
    assign o_ex_op2    = r_ex_op2;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for the ID/EX stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_imm;
    logic [15:0] ex_ctrl;
    logic [31:0] ex_op1, ex_op2;
    logic [31:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          full;
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [31:0] op1, op2, cnt;
    } exp_t;

    exp_t sb[$];

    id_ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .i_id_valid  (id_valid),
        .i_id_pc     (id_pc),
        .i_id_rs1    (id_rs1),
        .i_id_rs2    (id_rs2),
        .i_id_rd     (id_rd),
        .i_id_imm    (id_imm),
        .i_id_ctrl   (id_ctrl),
        .i_rf_rdata1 (rf_rdata1),
        .i_rf_rdata2 (rf_rdata2),
        .i_wb_regwrite(wb_regwrite),
        .i_wb_rd     (wb_rd),
        .i_wb_data   (wb_data),
        .i_flush     (flush),
        .o_stall     (stall),
        .o_ex_valid  (ex_valid),
        .o_ex_pc     (ex_pc),
        .o_ex_rs1    (ex_rs1),
        .o_ex_rs2    (ex_rs2),
        .o_ex_rd     (ex_rd),
        .o_ex_imm    (ex_imm),
        .o_ex_ctrl   (ex_ctrl),
        .o_ex_op1    (ex_op1),
        .o_ex_op2    (ex_op2),
        .o_stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t full(input logic v, input logic [31:0] pc,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic [31:0] imm,
                                  input logic [15:0] ctrl, input logic [31:0] op1,
                                  input logic [31:0] op2, input logic [31:0] cnt);
        exp_t e;
        e.full = 1'b1; e.valid = v; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.imm = imm; e.ctrl = ctrl; e.op1 = op1; e.op2 = op2; e.cnt = cnt;
        return e;
    endfunction

    function automatic exp_t bubble(input logic [31:0] cnt);
        exp_t e;
        e = full(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, cnt);
        e.full = 1'b0;
        return e;
    endfunction

    task automatic id_in(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] imm,
                         input logic [15:0] ctrl, input logic [31:0] d1, input logic [31:0] d2);
        id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_imm = imm; id_ctrl = ctrl; rf_rdata1 = d1; rf_rdata2 = d2;
    endtask

    task automatic wb_in(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_regwrite = we; wb_rd = rd; wb_data = d;
    endtask

    // Check the combinational stall, push the expected EX contents, clock once
    // and compare what the stage captured.
    task automatic step(input string tag, input logic exp_stall, input exp_t e);
        exp_t got;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".valid"}, 32'(ex_valid), 32'(got.valid));
        chk({tag, ".ctrl"}, 32'(ex_ctrl), 32'(got.ctrl));
        chk({tag, ".cnt"}, stall_cnt, got.cnt);
        if (got.full) begin
            chk({tag, ".pc"}, ex_pc, got.pc);
            chk({tag, ".rs1"}, 32'(ex_rs1), 32'(got.rs1));
            chk({tag, ".rs2"}, 32'(ex_rs2), 32'(got.rs2));
            chk({tag, ".rd"}, 32'(ex_rd), 32'(got.rd));
            chk({tag, ".imm"}, ex_imm, got.imm);
            chk({tag, ".op1"}, ex_op1, got.op1);
            chk({tag, ".op2"}, ex_op2, got.op2);
        end
        $display("step %s: valid=%0b pc=%08h op1=%08h op2=%08h ctrl=%04h cnt=%0d",
                 tag, ex_valid, ex_pc, ex_op1, ex_op2, ex_ctrl, stall_cnt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
        chk({tag, ".pc"}, ex_pc, 32'd0);
        chk({tag, ".rd"}, 32'(ex_rd), 32'd0);
        chk({tag, ".imm"}, ex_imm, 32'd0);
        chk({tag, ".ctrl"}, 32'(ex_ctrl), 32'd0);
        chk({tag, ".op1"}, ex_op1, 32'd0);
        chk({tag, ".op2"}, ex_op2, 32'd0);
        chk({tag, ".cnt"}, stall_cnt, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        id_in(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
        wb_in(1'b0, '0, '0);
        #2;
        chk_all_zero("reset_async");
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("reset_held");
        rst = 1'b0;

        // Pass-through
        id_in(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFF0, 16'h0004, 32'h11, 32'h22);
        step("pass", 1'b0, full(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFF0, 16'h0004, 32'h11, 32'h22, 32'd0));

        // Write-back bypass into both operands
        id_in(1'b1, 32'h44, 5'd5, 5'd5, 5'd6, 32'h8, 16'h0004, 32'h0, 32'h0);
        wb_in(1'b1, 5'd5, 32'hDEAD_BEEF);
        step("byp_both", 1'b0, full(1'b1, 32'h44, 5'd5, 5'd5, 5'd6, 32'h8, 16'h0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0));

        // x0 is never bypassed
        id_in(1'b1, 32'h48, 5'd0, 5'd5, 5'd6, 32'h0, 16'h0004, 32'h0, 32'h55);
        wb_in(1'b1, 5'd0, 32'hDEAD_BEEF);
        step("byp_x0", 1'b0, full(1'b1, 32'h48, 5'd0, 5'd5, 5'd6, 32'h0, 16'h0004, 32'h0, 32'h55, 32'd0));

        // Bypass only rs2
        id_in(1'b1, 32'h4C, 5'd8, 5'd9, 5'd10, 32'h1, 16'h0004, 32'h88, 32'h99);
        wb_in(1'b1, 5'd9, 32'hCAFE_F00D);
        step("byp_rs2", 1'b0, full(1'b1, 32'h4C, 5'd8, 5'd9, 5'd10, 32'h1, 16'h0004, 32'h88, 32'hCAFE_F00D, 32'd0));

        // Load into EX, then a dependent instruction stalls one cycle
        id_in(1'b1, 32'h50, 5'd1, 5'd2, 5'd7, 32'h4, 16'h0001, 32'h1, 32'h2);
        wb_in(1'b0, 5'd0, 32'h0);
        step("load1", 1'b0, full(1'b1, 32'h50, 5'd1, 5'd2, 5'd7, 32'h4, 16'h0001, 32'h1, 32'h2, 32'd0));
        id_in(1'b1, 32'h54, 5'd1, 5'd7, 5'd8, 32'hC, 16'h0004, 32'h101, 32'h202);
        wb_in(1'b1, 5'd7, 32'h777);
        step("lu_stall", 1'b1, bubble(32'd1));
        step("lu_replay", 1'b0, full(1'b1, 32'h54, 5'd1, 5'd7, 5'd8, 32'hC, 16'h0004, 32'h101, 32'h777, 32'd1));

        // Flush wins over a load-use hazard and is not counted
        id_in(1'b1, 32'h58, 5'd1, 5'd2, 5'd7, 32'h0, 16'h0001, 32'h3, 32'h4);
        wb_in(1'b0, 5'd0, 32'h0);
        step("load2", 1'b0, full(1'b1, 32'h58, 5'd1, 5'd2, 5'd7, 32'h0, 16'h0001, 32'h3, 32'h4, 32'd1));
        id_in(1'b1, 32'h5C, 5'd7, 5'd2, 5'd9, 32'h0, 16'h0004, 32'h5, 32'h6);
        flush = 1'b1;
        step("flush", 1'b0, bubble(32'd1));
        flush = 1'b0;

        // Invalid ID instruction: no hazard, control word zeroed
        id_in(1'b1, 32'h60, 5'd1, 5'd2, 5'd7, 32'h0, 16'h0001, 32'h0, 32'h0);
        step("load3", 1'b0, full(1'b1, 32'h60, 5'd1, 5'd2, 5'd7, 32'h0, 16'h0001, 32'h0, 32'h0, 32'd1));
        id_in(1'b0, 32'h64, 5'd7, 5'd7, 5'd11, 32'h0, 16'h00FF, 32'hA, 32'hB);
        step("invalid", 1'b0, full(1'b0, 32'h64, 5'd7, 5'd7, 5'd11, 32'h0, 16'h0000, 32'hA, 32'hB, 32'd1));

        // No false hazard: load to x0, then a non-load producer
        id_in(1'b1, 32'h68, 5'd0, 5'd0, 5'd0, 32'h0, 16'h0001, 32'h0, 32'h0);
        step("load_x0", 1'b0, full(1'b1, 32'h68, 5'd0, 5'd0, 5'd0, 32'h0, 16'h0001, 32'h0, 32'h0, 32'd1));
        id_in(1'b1, 32'h6C, 5'd0, 5'd0, 5'd3, 32'h0, 16'h0004, 32'h0, 32'h0);
        step("use_x0", 1'b0, full(1'b1, 32'h6C, 5'd0, 5'd0, 5'd3, 32'h0, 16'h0004, 32'h0, 32'h0, 32'd1));
        id_in(1'b1, 32'h70, 5'd3, 5'd3, 5'd4, 32'h0, 16'h0004, 32'h31, 32'h32);
        step("nonload", 1'b0, full(1'b1, 32'h70, 5'd3, 5'd3, 5'd4, 32'h0, 16'h0004, 32'h31, 32'h32, 32'd1));

        // Reset mid-stall clears everything asynchronously
        id_in(1'b1, 32'h74, 5'd1, 5'd2, 5'd7, 32'h0, 16'h0001, 32'h0, 32'h0);
        step("load4", 1'b0, full(1'b1, 32'h74, 5'd1, 5'd2, 5'd7, 32'h0, 16'h0001, 32'h0, 32'h0, 32'd1));
        id_in(1'b1, 32'h78, 5'd7, 5'd2, 5'd12, 32'h0, 16'h0004, 32'h21, 32'h22);
        #1;
        chk("pre_rst.stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        chk("mid_rst.stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst", 1'b0, full(1'b1, 32'h78, 5'd7, 5'd2, 5'd12, 32'h0, 16'h0004, 32'h21, 32'h22, 32'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage placed directly downstream of the register file in the RV32I core.
- Captures the two register-file read ports, along with the decoded fields and control word for the instruction in ID.
- Bypasses a same-cycle write-back into the captured operands.
- Detects load-use hazards, stalls the front end and inserts a bubble.
- Handles a branch/jump flush.

Parameters:
n, 32, data/address width
CTRL_W, 16, width of decoded control word
MEMREAD_BIT, 0, index of the memory-read flag inside the control word

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  n  PC of the ID instruction
id_rs1  in  5  source register 1 index (also drives register file ReadS1)
id_rs2  in  5  source register 2 index (also drives register file ReadS2)
id_rd  in  5  destination register index
id_imm  in  n  sign-extended immediate
id_ctrl  in  CTRL_W  decoded control word
rf_rdata1  in  n  register file ReadData1
rf_rdata2  in  n  register file ReadData2
wb_regwrite  in  1  write-back writes the register file this cycle
wb_rd  in  5  write-back destination (register file Writeaddr)
wb_data  in  n  write-back data (register file WriteData)
flush  in  1  kill the instruction entering EX (taken branch/jump)
stall  out  1  hold PC and IF/ID register
ex_valid  out  1  EX holds a real instruction
ex_pc  out  n  latched PC
ex_rs1, ex_rs2, ex_rd  out  5 each  latched register indices
ex_imm  out  n  latched immediate
ex_ctrl  out  CTRL_W  latched control word
ex_op1, ex_op2  out  n  latched operands
stall_cnt  out  32  number of load-use stall cycles since reset

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is asynchronous and active-high.
  - While rst=1, every registered output is 0: ex_valid, ex_pc, ex_rs1/rs2/rd, ex_imm, ex_ctrl, ex_op1/op2 and stall_cnt.
  - Release of rst takes effect at the next rising edge.
- Latency: exactly 1 cycle from the ID inputs to the ex_* outputs.
- Load-use hazard (combinational): hazard = id_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rd≠0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
- stall = hazard & ~flush. stall is combinational and is not registered.
- Write-back bypass (needed because the register file writes on the clock edge and reads combinationally):
  - op1_next = wb_data if (wb_regwrite & wb_rd≠0 & wb_rd==id_rs1), else rf_rdata1.
  - op2_next is the same rule on id_rs2.
  - x0 is never bypassed.
- Per-edge update, highest priority first:
  1. flush=1: ex_valid←0, ex_ctrl←0, other fields don't-care (implementation: hold). stall=0 in this cycle.
  2. stall=1 (bubble): ex_valid←0, ex_ctrl←0, and stall_cnt increments. The ID instruction is not consumed; upstream re-presents it next cycle.
  3. Otherwise: all ex_* fields ← ID inputs and bypassed operands; ex_valid←id_valid.
- Invalid instructions: when id_valid=0, ex_ctrl←0, so no side effects occur downstream.
- stall_cnt:
  - Saturates at 32'hFFFF_FFFF.
  - Does not wrap.
  - Cleared only by rst.
- Simultaneous events:
  - flush with hazard: flush wins, and no stall cycle is counted.
  - Bypass with hazard: the bypass is computed but discarded, because a bubble is inserted.
  - Both rs1 and rs2 match wb_rd: both operands are bypassed.
- Reset mid-stall: stall drops immediately because ex_valid is 0. The ID instruction proceeds on the first edge after release.

Decomposition:
- Shared package (core-wide):
  - CTRL_W and MEMREAD_BIT.
  - Register index width 5 and data width 32.
  - Control-word bit positions.
- Sub-module hazard_unit:
  - Purely combinational.
  - Inputs: id/ex register indices, ex memread and valid bits, flush.
  - Output: stall.
  - Instantiated once.
- Pipeline flops are reused from the core's existing n-bit load register where convenient, with load = ~stall.

Test Plan:
1. Reset: assert rst mid-run with ex_valid=1 -> all ex_* outputs and stall_cnt read 0 immediately, asynchronously, before any edge.
2. Pass-through: id_valid=1, id_pc=0x40, rf_rdata1=0x11, rf_rdata2=0x22, id_imm=0xFFFF_FFF0 -> one edge later ex_valid=1, ex_pc=0x40, ex_op1=0x11, ex_op2=0x22, ex_imm=0xFFFF_FFF0.
3. Write-back bypass:
   - id_rs1=5, id_rs2=5, wb_regwrite=1, wb_rd=5, wb_data=0xDEAD_BEEF, rf_rdata=0 -> ex_op1=ex_op2=0xDEAD_BEEF.
   - Repeat with wb_rd=0 and id_rs1=0 -> ex_op1=0.
4. Load-use stall:
   - Setup: EX holds a load with ex_rd=7; ID id_rs2=7.
   - Expected: stall=1; next edge ex_valid=0, ex_ctrl=0, stall_cnt=1.
   - Next cycle: stall=0 and the instruction enters EX.
5. Flush priority: same setup as test 4 with flush=1 -> stall=0, ex_valid=0 next edge, stall_cnt unchanged.
6. No false hazard:
   - EX load with ex_rd=0 and id_rs1=0 -> stall=0.
   - EX non-load with ex_rd=id_rs1=3 -> stall=0.
